// File: rtl/axis_width_downsizer_if.sv
// AXI-Stream bundle used on both sides of the width downsizer.
// The master side drives payload and valid; the slave side drives ready.
interface axis_width_downsizer_if #(
   parameter int DATA_W = 8,
   parameter int KEEP_W = 1
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tlast;

   modport master (output tvalid, tdata, tkeep, tlast, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_width_downsizer.sv
// Wide-to-narrow AXI-Stream converter: emits the kept lanes of each input beat
// lowest first, one per cycle, with TLAST moved to the final emitted lane.
module axis_width_downsizer #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8
) (
   input  logic                   s_axis_clk,
   input  logic                   s_axis_reset,
   axis_width_downsizer_if.slave  s_axis,
   axis_width_downsizer_if.master m_axis,
   output logic                   busy_o,
   output logic                   null_beat_o
);
   localparam int RATIO = IN_WIDTH / OUT_WIDTH;

   logic                 hold_valid_q, hold_valid_d;
   logic [IN_WIDTH-1:0]  hold_data_q, hold_data_d;
   logic                 hold_last_q, hold_last_d;
   logic [RATIO-1:0]     pend_q, pend_d;
   logic                 null_q, null_d;

   logic [RATIO-1:0]     lo_mask, pend_rest;
   logic                 pend_onehot, in_hs, out_hs, in_null;
   logic [OUT_WIDTH-1:0] lane_data;

   // Isolate the lowest pending lane; what remains after it tells us if it is the last one.
   assign lo_mask     = pend_q & (~pend_q + RATIO'(1));
   assign pend_rest   = pend_q & ~lo_mask;
   assign pend_onehot = (pend_q != '0) && (pend_rest == '0);

   always_comb begin
      lane_data = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (lo_mask[k]) lane_data = lane_data | hold_data_q[k*OUT_WIDTH +: OUT_WIDTH];
      end
   end

   // Ready looks through to downstream ready so a new beat loads as the last lane leaves.
   assign s_axis.tready = !s_axis_reset && (!hold_valid_q || (m_axis.tready && pend_onehot));
   assign m_axis.tvalid = !s_axis_reset && hold_valid_q;
   assign m_axis.tdata  = s_axis_reset ? '0 : lane_data;
   assign m_axis.tlast  = !s_axis_reset && hold_last_q && pend_onehot;
   assign m_axis.tkeep  = '1;
   assign busy_o        = hold_valid_q;
   assign null_beat_o   = null_q;

   assign in_hs   = s_axis.tvalid && s_axis.tready;
   assign out_hs  = m_axis.tvalid && m_axis.tready;
   assign in_null = in_hs && (s_axis.tkeep == '0);

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      pend_d       = pend_q;
      null_d       = in_null;
      if (in_hs && !in_null) begin
         hold_valid_d = 1'b1;
         hold_data_d  = s_axis.tdata;
         hold_last_d  = s_axis.tlast;
         pend_d       = s_axis.tkeep;
      end else if (out_hs) begin
         pend_d = pend_rest;
         if (pend_rest == '0) hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge s_axis_clk) begin
      if (s_axis_reset) begin
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_last_q  <= 1'b0;
         pend_q       <= '0;
         null_q       <= 1'b0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_last_q  <= hold_last_d;
         pend_q       <= pend_d;
         null_q       <= null_d;
      end
   end
endmodule

// File: tb/tb_axis_width_downsizer.sv
// Directed scoreboard bench for the 32->8 AXI-Stream width downsizer.
module tb_axis_width_downsizer;
   logic clk = 1'b0;
   logic rst;
   logic busy, nullb;

   axis_width_downsizer_if #(.DATA_W(32), .KEEP_W(4)) s_if ();
   axis_width_downsizer_if #(.DATA_W(8),  .KEEP_W(1)) m_if ();

   axis_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
      .s_axis_clk   (clk),
      .s_axis_reset (rst),
      .s_axis       (s_if.slave),
      .m_axis       (m_if.master),
      .busy_o       (busy),
      .null_beat_o  (nullb)
   );

   always #5 clk = ~clk;

   logic [8:0] sb[$];
   int n_cmp = 0, n_err = 0;
   int cyc = 0, hs_cnt = 0, hs_first = 0, hs_last = 0, tlast_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Negedge half: scoreboard every output handshake that the coming edge will take.
   task automatic tick_n();
      logic [8:0] e;
      @(negedge clk);
      cyc++;
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
         hs_cnt++;
         if (hs_cnt == 1) hs_first = cyc;
         hs_last = cyc;
         if (m_if.tlast === 1'b1) tlast_cnt++;
         if (sb.size() == 0) chk("unexpected_beat", {1'b1, m_if.tdata}, 0);
         else begin
            e = sb.pop_front();
            chk("out_data", m_if.tdata, e[7:0]);
            chk("out_last", m_if.tlast, e[8]);
         end
      end
   endtask

   task automatic tick_p();
      @(posedge clk);
      #1;
   endtask

   task automatic hs_clear();
      hs_cnt = 0; hs_first = 0; hs_last = 0; tlast_cnt = 0;
   endtask

   task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int lastk;
      lastk = -1;
      for (int i = 0; i < 4; i++) if (k[i]) lastk = i;
      for (int i = 0; i < 4; i++)
         if (k[i]) sb.push_back({l && (i == lastk), d[i*8 +: 8]});
   endtask

   task automatic send_raw(input logic [31:0] d, input logic [3:0] k, input logic l);
      bit acc;
      acc = 0;
      s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l;
      for (int c = 0; c < 40 && !acc; c++) begin
         tick_n();
         acc = (s_if.tready === 1'b1);
         tick_p();
      end
      s_if.tvalid = 1'b0;
      chk("accept", acc, 1);
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
      push_beat(d, k, l);
      send_raw(d, k, l);
   endtask

   task automatic drain();
      for (int c = 0; c < 100 && sb.size() != 0; c++) begin
         tick_n();
         tick_p();
      end
      chk("drain_left", sb.size(), 0);
   endtask

   initial begin
      logic [7:0] stall_data;
      rst = 1'b1;
      s_if.tvalid = 1'b1; s_if.tdata = 32'h12345678; s_if.tkeep = 4'hF; s_if.tlast = 1'b0;
      m_if.tready = 1'b1;

      // 1: reset with input valid held high
      for (int i = 0; i < 2; i++) begin
         tick_n();
         chk("rst_s_tready", s_if.tready, 0);
         chk("rst_m_tvalid", m_if.tvalid, 0);
         chk("rst_m_tdata", m_if.tdata, 0);
         tick_p();
      end
      rst = 1'b0; s_if.tvalid = 1'b0;
      tick_n();
      chk("post_rst_s_tready", s_if.tready, 1);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_null", nullb, 0);
      tick_p();

      // 2: single full beat
      hs_clear();
      send(32'hDDCCBBAA, 4'hF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick_n();
         chk("t2_m_tvalid", m_if.tvalid, 1);
         if (i == 3) chk("t2_s_tready_dd", s_if.tready, 1);
         tick_p();
      end
      chk("t2_count", hs_cnt, 4);
      chk("t2_span", hs_last - hs_first, 3);
      chk("t2_tlast_cnt", tlast_cnt, 1);

      // 3: three back-to-back beats, no gap
      hs_clear();
      send(32'h03020100, 4'hF, 1'b0);
      send(32'h07060504, 4'hF, 1'b0);
      send(32'h0B0A0908, 4'hF, 1'b1);
      drain();
      chk("t3_count", hs_cnt, 12);
      chk("t3_span", hs_last - hs_first, 11);
      chk("t3_tlast_cnt", tlast_cnt, 1);

      // 4: downstream stalls every other cycle; next beat waits for the last lane
      hs_clear();
      send(32'h44332211, 4'hF, 1'b1);
      push_beat(32'h88776655, 4'hF, 1'b1);
      s_if.tvalid = 1'b1; s_if.tdata = 32'h88776655; s_if.tkeep = 4'hF; s_if.tlast = 1'b1;
      stall_data = 8'h00;
      for (int c = 0; c < 7; c++) begin
         m_if.tready = (c % 2 == 0);
         tick_n();
         chk("t4_s_tready", s_if.tready, (c == 6));
         chk("t4_m_tvalid", m_if.tvalid, 1);
         if (c % 2 == 1) stall_data = m_if.tdata;
         else if (c > 0) chk("t4_stable", m_if.tdata, stall_data);
         tick_p();
      end
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;
      drain();
      chk("t4_count", hs_cnt, 8);

      // 5: partial and non-contiguous keep
      hs_clear();
      send(32'h44332211, 4'h3, 1'b1);
      send(32'h44332211, 4'h5, 1'b1);
      drain();
      chk("t5_count", hs_cnt, 4);
      chk("t5_span", hs_last - hs_first, 3);
      chk("t5_tlast_cnt", tlast_cnt, 2);

      // 6a: all-lanes-clear beat is dropped
      hs_clear();
      send(32'hCAFEF00D, 4'h0, 1'b1);
      tick_n();
      chk("t6_null_pulse", nullb, 1);
      chk("t6_null_m_tvalid", m_if.tvalid, 0);
      tick_p();
      tick_n();
      chk("t6_null_clear", nullb, 0);
      tick_p();
      chk("t6_null_outputs", hs_cnt, 0);

      // 6b: reset after two of four lanes
      hs_clear();
      sb.push_back({1'b0, 8'h11});
      sb.push_back({1'b0, 8'h22});
      send_raw(32'h44332211, 4'hF, 1'b1);
      tick_n(); tick_p();
      tick_n(); tick_p();
      rst = 1'b1;
      tick_n();
      chk("t6_rst_m_tvalid", m_if.tvalid, 0);
      tick_p();
      rst = 1'b0;
      tick_n();
      chk("t6_after_rst_m_tvalid", m_if.tvalid, 0);
      chk("t6_after_rst_busy", busy, 0);
      tick_p();
      chk("t6_partial_count", hs_cnt, 2);
      send(32'h88776655, 4'hF, 1'b1);
      drain();
      chk("t6_total_count", hs_cnt, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
